roc_encoder: RTL

- Rank-order-coding (ROC) front end that sits directly upstream of the SNN core's AER input.
- Buffers one image of IMAGE_SIZE pixels received over a valid/ready pixel stream.
- Emits one AER event per pixel whose value is at or above a threshold, brightest first; pixels of equal value are emitted in ascending index order.
- Drives the core's 4-phase AER req/ack input, replacing the bench-side image-to-spike conversion in hardware.

---
 rtl/roc_encoder_pkg.sv | 22 ++
 rtl/roc_level_prio_enc.sv | 31 +++
 rtl/roc_encoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/roc_encoder_pkg.sv
// rtl/roc_encoder_pkg.sv - shared sizes and FSM encoding for the rank-order-coding encoder
//
// Default image geometry and the encoder state type. The package is imported
// by the level priority encoder and by the top level.
package pa_SnnAccelerator;

    localparam int PIXEL_BITS = 8;
    localparam int IMAGE_SIZE = 256;
    localparam int M          = 8;
    localparam int NUM_LEVELS = 2**PIXEL_BITS;

    typedef enum logic [2:0] {
        LOAD,
        SEEK,
        SCAN,
        SETUP,
        WAIT_ACK_HI,
        WAIT_ACK_LO,
        FINISH
    } roc_state_t;

endpackage

// File: rtl/roc_level_prio_enc.sv
// rtl/roc_level_prio_enc.sv - finds the highest populated pixel level strictly below a ceiling
//
// Ports:
//   bitmap  : one bit per pixel level, set when the image holds that level
//   ceiling : exclusive upper bound; 2**LVL_BITS searches the whole bitmap
//   found   : a populated level below the ceiling exists
//   level   : highest such level (0 when found is low)
module roc_level_prio_enc
    import pa_SnnAccelerator::*;
#(
    parameter int LVL_BITS = PIXEL_BITS
) (
    input  logic [2**LVL_BITS-1:0] bitmap,
    input  logic [LVL_BITS:0]      ceiling,
    output logic                   found,
    output logic [LVL_BITS-1:0]    level
);

    // Ascending scan: the last qualifying bit written wins, giving the highest level.
    always_comb begin
        found = 1'b0;
        level = '0;
        for (int i = 0; i < 2**LVL_BITS; i++) begin
            if (bitmap[i] && ((LVL_BITS+1)'(i) < ceiling)) begin
                found = 1'b1;
                level = LVL_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/roc_encoder.sv
// rtl/roc_encoder.sv - buffers one image and emits AER events brightest-first, ties by index
//
// Ports:
//   CLK, RST           : clock, asynchronous active-low reset
//   PIX_DATA/VALID/READY : pixel stream, pixels in index order
//   THR_LEVEL          : minimum emitted level, captured with pixel 0
//   AER_ADDR/REQ/ACK   : 4-phase AER output; ACK is asynchronous to CLK
//   BUSY               : image loaded or being encoded
//   DONE               : one-cycle pulse after the last handshake of an image
//   EVT_COUNT          : events emitted for the current image
module roc_encoder #(
    parameter int         PIXEL_BITS = pa_SnnAccelerator::PIXEL_BITS,
    parameter int         IMAGE_SIZE = pa_SnnAccelerator::IMAGE_SIZE,
    parameter int         M          = pa_SnnAccelerator::M,
    parameter logic [1:0] EVT_TYPE   = 2'b00,
    parameter int         ADDR_SETUP = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PIXEL_BITS-1:0] PIX_DATA,
    input  logic                  PIX_VALID,
    output logic                  PIX_READY,
    input  logic [PIXEL_BITS-1:0] THR_LEVEL,
    output logic [M+1:0]          AER_ADDR,
    output logic                  AER_REQ,
    input  logic                  AER_ACK,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [M:0]            EVT_COUNT
);
    import pa_SnnAccelerator::*;

    localparam int           LEVELS   = 2**PIXEL_BITS;
    localparam int           SW       = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
    localparam logic [M-1:0] LAST_IDX = M'(IMAGE_SIZE-1);

    roc_state_t            state, state_nx;
    logic                  ack_m, ack_s;
    logic [PIXEL_BITS-1:0] pix_buf [IMAGE_SIZE];
    logic [LEVELS-1:0]     bitmap;
    logic [M-1:0]          wr_idx, rd_idx;
    logic [PIXEL_BITS-1:0] thr;
    logic [PIXEL_BITS:0]   cur_level;
    logic [SW-1:0]         setup_cnt;
    logic                  enc_found;
    logic [PIXEL_BITS-1:0] enc_level;
    logic                  pix_acc, hit, seek_go, setup_done;

    roc_level_prio_enc #(.LVL_BITS(PIXEL_BITS)) u_prio (
        .bitmap  (bitmap),
        .ceiling (cur_level),
        .found   (enc_found),
        .level   (enc_level)
    );

    assign PIX_READY  = (state == LOAD);
    assign pix_acc    = PIX_VALID && (state == LOAD);
    assign hit        = ({1'b0, pix_buf[rd_idx]} == cur_level);
    // Level 0 is a "dark" pixel and never produces an event, whatever the threshold.
    assign seek_go    = enc_found && (enc_level >= thr) && (enc_level != '0);
    assign setup_done = (setup_cnt == SW'(ADDR_SETUP-1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= LOAD;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:        if (pix_acc && (wr_idx == LAST_IDX)) state_nx = SEEK;
            SEEK:        state_nx = seek_go ? SCAN : FINISH;
            SCAN: begin
                if (hit)                       state_nx = SETUP;
                else if (rd_idx == LAST_IDX)   state_nx = SEEK;
            end
            SETUP:       if (setup_done) state_nx = WAIT_ACK_HI;
            WAIT_ACK_HI: if (ack_s)      state_nx = WAIT_ACK_LO;
            WAIT_ACK_LO: if (!ack_s)     state_nx = (rd_idx == LAST_IDX) ? SEEK : SCAN;
            FINISH:      state_nx = LOAD;
            default:     state_nx = LOAD;
        endcase
    end

    // Pixel store carries no reset: its contents are always rewritten before use.
    always_ff @(posedge CLK) begin
        if (pix_acc) pix_buf[wr_idx] <= PIX_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_m     <= 1'b0;
            ack_s     <= 1'b0;
            bitmap    <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            thr       <= '0;
            cur_level <= '0;
            setup_cnt <= '0;
            AER_ADDR  <= '0;
            AER_REQ   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            EVT_COUNT <= '0;
        end else begin
            ack_m <= AER_ACK;
            ack_s <= ack_m;
            DONE  <= 1'b0;
            case (state)
                LOAD: if (pix_acc) begin
                    bitmap[PIX_DATA] <= 1'b1;
                    wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
                    if (wr_idx == '0) begin
                        thr       <= THR_LEVEL;
                        BUSY      <= 1'b1;
                        EVT_COUNT <= '0;
                    end
                    if (wr_idx == LAST_IDX) cur_level <= (PIXEL_BITS+1)'(LEVELS);
                end
                SEEK: begin
                    if (seek_go) begin
                        cur_level <= {1'b0, enc_level};
                        rd_idx    <= '0;
                    end else begin
                        BUSY <= 1'b0;
                        DONE <= 1'b1;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        AER_ADDR  <= {EVT_TYPE, rd_idx};
                        setup_cnt <= '0;
                    end else if (rd_idx != LAST_IDX) begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                SETUP: begin
                    if (setup_done) AER_REQ   <= 1'b1;
                    else            setup_cnt <= setup_cnt + 1'b1;
                end
                WAIT_ACK_HI: if (ack_s) begin
                    AER_REQ   <= 1'b0;
                    EVT_COUNT <= EVT_COUNT + 1'b1;
                end
                WAIT_ACK_LO: if (!ack_s && (rd_idx != LAST_IDX)) rd_idx <= rd_idx + 1'b1;
                FINISH:      bitmap <= '0;
                default:     ;
            endcase
        end
    end

endmodule
